// File: rtl/lcd_4bits_reader.sv
// Reads one byte from a 4-bit HD44780-style LCD bus as two E-strobed nibbles.
// Optional busy polling is enabled by defining LCD_READER_BUSY_POLL_EN.
module lcd_4bits_reader #(
  parameter int unsigned SETUP_CYC  = 2,
  parameter int unsigned E_HIGH_CYC = 20,
  parameter int unsigned GAP_CYC    = 50
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       rs,
  input  logic       poll,
  input  logic [3:0] SF_D,
  output logic       LCD_E,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic       bus_req,
  output logic       ready,
  output logic [7:0] data,
  output logic       valid,
  output logic       timeout
);

  localparam int unsigned MAX_A   = (SETUP_CYC > E_HIGH_CYC) ? SETUP_CYC : E_HIGH_CYC;
  localparam int unsigned MAX_CYC = (MAX_A > GAP_CYC) ? MAX_A : GAP_CYC;
  localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] SETUP = 3'd1;
  localparam logic [2:0] E_HI1 = 3'd2;
  localparam logic [2:0] GAP1  = 3'd3;
  localparam logic [2:0] E_HI2 = 3'd4;
  localparam logic [2:0] GAP2  = 3'd5;
  localparam logic [2:0] DONE  = 3'd6;

  logic [2:0]       state;
  logic [2:0]       state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic [3:0]       nib_hi;
  logic [3:0]       nib_lo;
  logic             last_c;
  logic             xfer_c;
  logic             repoll_c;
  logic             rs_sel_c;

  assign last_c = (cnt == '0);

`ifdef LCD_READER_BUSY_POLL_EN
  logic       poll_mode;
  logic [9:0] poll_cnt;

  // Busy polls always read the busy flag register.
  assign rs_sel_c = rs & ~poll;
  assign repoll_c = poll_mode && nib_hi[3] && (poll_cnt != 10'd1023);

  // Poll bookkeeping: poll_cnt is the number of completed reads minus one.
  always_ff @(posedge clock) begin
    if (!reset) begin
      poll_mode <= 1'b0;
      poll_cnt  <= 10'd0;
      timeout   <= 1'b0;
    end else begin
      timeout <= (state == GAP2) && last_c && !repoll_c && poll_mode && nib_hi[3];
      if (state == IDLE && start) begin
        poll_mode <= poll;
        poll_cnt  <= 10'd0;
      end else if (state == GAP2 && last_c && repoll_c) begin
        poll_cnt <= poll_cnt + 10'd1;
      end
    end
  end
`else
  logic unused_poll;

  assign unused_poll = poll;
  assign rs_sel_c    = rs;
  assign repoll_c    = 1'b0;
  assign timeout     = 1'b0;
`endif

  // Next state; the shared down-counter is reloaded on every state entry.
  always_comb begin
    state_next = state;
    cnt_next   = last_c ? cnt : cnt - CNT_W'(1);
    xfer_c     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = SETUP;
          cnt_next   = CNT_W'(SETUP_CYC - 1);
        end
      end
      SETUP: begin
        if (last_c) begin
          state_next = E_HI1;
          cnt_next   = CNT_W'(E_HIGH_CYC - 1);
        end
      end
      E_HI1: begin
        if (last_c) begin
          state_next = GAP1;
          cnt_next   = CNT_W'(GAP_CYC - 1);
        end
      end
      GAP1: begin
        if (last_c) begin
          state_next = E_HI2;
          cnt_next   = CNT_W'(E_HIGH_CYC - 1);
        end
      end
      E_HI2: begin
        if (last_c) begin
          state_next = GAP2;
          cnt_next   = CNT_W'(GAP_CYC - 1);
        end
      end
      GAP2: begin
        if (last_c) begin
          if (repoll_c) begin
            state_next = SETUP;
            cnt_next   = CNT_W'(SETUP_CYC - 1);
          end else begin
            state_next = DONE;
            cnt_next   = '0;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
    xfer_c = (state_next == SETUP) || (state_next == E_HI1) || (state_next == GAP1) ||
             (state_next == E_HI2) || (state_next == GAP2);
  end

  // State, nibble capture and registered pin/status outputs.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      nib_hi  <= 4'h0;
      nib_lo  <= 4'h0;
      LCD_E   <= 1'b0;
      LCD_RS  <= 1'b0;
      LCD_RW  <= 1'b0;
      bus_req <= 1'b0;
      ready   <= 1'b1;
      data    <= 8'h00;
      valid   <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (state == E_HI1 && last_c) nib_hi <= SF_D;
      if (state == E_HI2 && last_c) nib_lo <= SF_D;
      if (state_next == DONE) data <= {nib_hi, nib_lo};
      if (state == IDLE && start) begin
        LCD_RS <= rs_sel_c;
      end else if (!xfer_c) begin
        LCD_RS <= 1'b0;
      end
      LCD_E   <= (state_next == E_HI1) || (state_next == E_HI2);
      LCD_RW  <= xfer_c;
      bus_req <= xfer_c;
      ready   <= (state_next == IDLE);
      valid   <= (state_next == DONE);
    end
  end

endmodule

// File: tb/tb_lcd_4bits_reader.sv
// Directed bench for lcd_4bits_reader: cycle table for one read plus multi-cycle
// sequences for ignored starts, reset aborts and (optionally) busy polling.
module tb_lcd_4bits_reader;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic       rs;
  logic       poll;
  logic [3:0] sf_tb;
  logic [3:0] sf_model = 4'h0;
  logic [3:0] SF_D;
  logic       model_en;
  logic       LCD_E, LCD_RS, LCD_RW, bus_req, ready, valid, timeout;
  logic [7:0] data;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  assign SF_D = model_en ? sf_model : sf_tb;

  lcd_4bits_reader dut (
    .clock(clock), .reset(reset), .start(start), .rs(rs), .poll(poll), .SF_D(SF_D),
    .LCD_E(LCD_E), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW), .bus_req(bus_req),
    .ready(ready), .data(data), .valid(valid), .timeout(timeout)
  );

  // LCD-side responder: nibble depends on how many E pulses have completed.
  int   falls = 0;
  int   fall_base = 0;
  int   mode = 0;
  logic e_q = 1'b0;

  function automatic logic [3:0] model_nib(input int m, input int idx);
    if (m == 2) return 4'hF;
    if (idx / 2 < 3) return (idx % 2 == 0) ? 4'h8 : 4'h0;
    return (idx % 2 == 0) ? 4'h0 : 4'h5;
  endfunction

  always @(negedge clock) begin
    if (e_q && !LCD_E) falls <= falls + 1;
    e_q      <= LCD_E;
    sf_model <= model_nib(mode, falls - fall_base);
  end

`ifdef LCD_READER_BUSY_POLL_EN
  logic       start2;
  logic       LCD_E2, LCD_RS2, LCD_RW2, bus_req2, ready2, valid2, timeout2;
  logic [7:0] data2;
  logic [3:0] sf2 = 4'hF;
  int         rises2 = 0;
  logic       e2_q = 1'b0;

  lcd_4bits_reader #(.SETUP_CYC(2), .E_HIGH_CYC(2), .GAP_CYC(2)) dut2 (
    .clock(clock), .reset(reset), .start(start2), .rs(1'b0), .poll(1'b1), .SF_D(sf2),
    .LCD_E(LCD_E2), .LCD_RS(LCD_RS2), .LCD_RW(LCD_RW2), .bus_req(bus_req2),
    .ready(ready2), .data(data2), .valid(valid2), .timeout(timeout2)
  );

  always @(negedge clock) begin
    if (!e2_q && LCD_E2) rises2 <= rises2 + 1;
    e2_q <= LCD_E2;
  end
`endif

  typedef struct {
    int         cyc;
    logic [6:0] pins;  // {E, RS, RW, bus_req, ready, valid, timeout}
    logic [7:0] d;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pins"}, 32'({LCD_E, LCD_RS, LCD_RW, bus_req, ready, valid, timeout}),
        32'(7'b0000100));
    chk({tag, "_data"}, 32'(data), 32'h00);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int   vcount, vcyc, r1, r2, f1, f2, nrise, rsrw_bad, n;
    int   v1, v2;
    logic ep;
    logic [7:0] d143, d287;
    logic rdy144, bus145, rs145;
    logic [7:0] exp_data;
    int   exp_falls;
    logic exp_rs;

    tbl[0]  = '{0,   7'b0000100, 8'h00};
    tbl[1]  = '{1,   7'b0111000, 8'h00};
    tbl[2]  = '{2,   7'b0111000, 8'h00};
    tbl[3]  = '{3,   7'b1111000, 8'h00};
    tbl[4]  = '{22,  7'b1111000, 8'h00};
    tbl[5]  = '{23,  7'b0111000, 8'h00};
    tbl[6]  = '{72,  7'b0111000, 8'h00};
    tbl[7]  = '{73,  7'b1111000, 8'h00};
    tbl[8]  = '{92,  7'b1111000, 8'h00};
    tbl[9]  = '{93,  7'b0111000, 8'h00};
    tbl[10] = '{142, 7'b0111000, 8'h00};
    tbl[11] = '{143, 7'b0000010, 8'h41};
    tbl[12] = '{144, 7'b0000100, 8'h41};

    reset = 1'b0; start = 1'b0; rs = 1'b0; poll = 1'b0; sf_tb = 4'h0; model_en = 1'b0;
`ifdef LCD_READER_BUSY_POLL_EN
    start2 = 1'b0;
`endif
    repeat (3) tick();
    chk_reset_vals("reset");
    reset = 1'b1;
    tick();

    // Single read, rs=1, nibbles 4 then 1.
    rs = 1'b1; vcount = 0; vcyc = -1; r1 = -1; r2 = -1; f1 = -1; f2 = -1; nrise = 0;
    rsrw_bad = 0; ep = 1'b0;
    for (int c = 0; c <= 145; c++) begin
      sf_tb = (c >= 3 && c <= 22) ? 4'h4 : (c >= 73 && c <= 92) ? 4'h1 : 4'hA;
      for (int i = 0; i < 13; i++) begin
        if (tbl[i].cyc == c) begin
          chk($sformatf("xfer_pins_c%0d", c),
              32'({LCD_E, LCD_RS, LCD_RW, bus_req, ready, valid, timeout}), 32'(tbl[i].pins));
          chk($sformatf("xfer_data_c%0d", c), 32'(data), 32'(tbl[i].d));
        end
      end
      if (valid) begin vcount++; vcyc = c; end
      if (LCD_E && !ep) begin nrise++; if (r1 < 0) r1 = c; else r2 = c; end
      if (!LCD_E && ep) begin if (f1 < 0) f1 = c; else f2 = c; end
      ep = LCD_E;
      if (c >= 1 && c <= 142 && !(LCD_RS && LCD_RW)) rsrw_bad++;
      start = (c == 0);
      tick();
    end
    start = 1'b0;
    chk("valid_count", 32'(vcount), 32'd1);
    chk("valid_cycle", 32'(vcyc), 32'd143);
    chk("e_rise_count", 32'(nrise), 32'd2);
    chk("e_rise1", 32'(r1), 32'd3);
    chk("e_fall1", 32'(f1), 32'd23);
    chk("e_rise2", 32'(r2), 32'd73);
    chk("e_fall2", 32'(f2), 32'd93);
    chk("rs_rw_stable", 32'(rsrw_bad), 32'd0);

    // Starts at 10 and 143 ignored; start at 144 begins a second read.
    rs = 1'b0; vcount = 0; v1 = -1; v2 = -1; d143 = 8'h00; d287 = 8'h00;
    rdy144 = 1'b0; bus145 = 1'b0; rs145 = 1'b1;
    for (int c = 0; c <= 289; c++) begin
      if (c >= 3 && c <= 22) sf_tb = 4'h7;
      else if (c >= 73 && c <= 92) sf_tb = 4'hC;
      else if (c >= 147 && c <= 166) sf_tb = 4'h3;
      else if (c >= 217 && c <= 236) sf_tb = 4'h9;
      else sf_tb = 4'hA;
      if (valid) begin vcount++; if (v1 < 0) v1 = c; else v2 = c; end
      if (c == 143) d143 = data;
      if (c == 287) d287 = data;
      if (c == 144) rdy144 = ready;
      if (c == 145) begin bus145 = bus_req; rs145 = LCD_RS; end
      start = (c == 0 || c == 10 || c == 143 || c == 144);
      tick();
    end
    start = 1'b0;
    chk("ign_valid_count", 32'(vcount), 32'd2);
    chk("ign_valid1_cycle", 32'(v1), 32'd143);
    chk("ign_valid2_cycle", 32'(v2), 32'd287);
    chk("ign_data1", 32'(d143), 32'h7C);
    chk("ign_data2", 32'(d287), 32'h39);
    chk("ready_c144", 32'(rdy144), 32'd1);
    chk("bus_req_c145", 32'(bus145), 32'd1);
    chk("lcd_rs_c145", 32'(rs145), 32'd0);

    // Reset at cycle 50 of a read.
    rs = 1'b1; sf_tb = 4'h5;
    for (int c = 0; c <= 50; c++) begin
      start = (c == 0);
      reset = (c != 50);
      tick();
    end
    reset = 1'b1; start = 1'b0;
    chk_reset_vals("rst_mid");
    vcount = 0;
    repeat (200) begin if (valid) vcount++; tick(); end
    chk("rst_mid_no_valid", 32'(vcount), 32'd0);

    // Reset while E is high, together with a start that must be ignored.
    for (int c = 0; c <= 79; c++) begin
      start = (c == 0);
      tick();
    end
    start = 1'b0;
    chk("e_high_before_rst", 32'(LCD_E), 32'd1);
    reset = 1'b0; start = 1'b1;
    tick();
    reset = 1'b1; start = 1'b0;
    chk_reset_vals("rst_e_hi");
    vcount = 0; n = 0;
    repeat (200) begin if (valid) vcount++; if (bus_req) n++; tick(); end
    chk("rst_e_hi_no_valid", 32'(vcount), 32'd0);
    chk("start_in_reset_ignored", 32'(n), 32'd0);

    // Busy poll request.
`ifdef LCD_READER_BUSY_POLL_EN
    exp_rs = 1'b0; exp_data = 8'h05; exp_falls = 8;
`else
    exp_rs = 1'b1; exp_data = 8'h80; exp_falls = 2;
`endif
    model_en = 1'b1; mode = 1; fall_base = falls;
    rs = 1'b1; poll = 1'b1; start = 1'b1;
    tick();
    start = 1'b0; poll = 1'b0;
    chk("poll_lcd_rs", 32'(LCD_RS), 32'(exp_rs));
    chk("poll_lcd_rw", 32'(LCD_RW), 32'd1);
    n = 0;
    while (!valid && n < 2000) begin tick(); n++; end
    if (n >= 2000) chk("poll_valid_wait", 32'd0, 32'd1);
    chk("poll_data", 32'(data), 32'(exp_data));
    chk("poll_timeout", 32'(timeout), 32'd0);
    chk("poll_e_pulses", 32'(falls - fall_base), 32'(exp_falls));
    tick();
    vcount = 0;
    repeat (200) begin if (valid) vcount++; tick(); end
    chk("poll_single_valid", 32'(vcount), 32'd0);
    model_en = 1'b0;

`ifdef LCD_READER_BUSY_POLL_EN
    // Stuck busy flag: gives up after 1024 reads.
    n = rises2;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    v1 = 0;
    while (!valid2 && v1 < 12000) begin tick(); v1++; end
    if (v1 >= 12000) chk("stuck_valid_wait", 32'd0, 32'd1);
    chk("stuck_valid_timeout", 32'({valid2, timeout2}), 32'b11);
    chk("stuck_data", 32'(data2), 32'hFF);
    chk("stuck_reads", 32'((rises2 - n) / 2), 32'd1024);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
